pipe_hazard_scoreboard: RTL and testbench



---
 rtl/pipe_hazard_scoreboard.sv | 175 +++++++++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding controller sitting beside ID: tracks in-flight RF writes, stalls on unready
// producers, picks forwarding sources and flushes IF on taken transfers.
// Optional performance counters: define HAZARD_PERF_COUNTERS_EN.
module pipe_hazard_scoreboard #(
    parameter int ID_LENGTH  = 3,
    parameter int NUM_STAGES = 3,
    parameter int ALU_LAT    = 1,
    parameter int LOAD_LAT   = 2,
    localparam int FWD_W     = $clog2(NUM_STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [ID_LENGTH-1:0] id_src1,
    input  logic [ID_LENGTH-1:0] id_src2,
    input  logic                 id_src1_used,
    input  logic                 id_src2_used,
    input  logic [ID_LENGTH-1:0] id_dst,
    input  logic                 id_wr_en,
    input  logic                 id_is_load,
    input  logic                 id_branch_taken,
    output logic                 stall,
    output logic                 flush_if,
    output logic [FWD_W-1:0]     fwd_sel1,
    output logic [FWD_W-1:0]     fwd_sel2,
    output logic [FWD_W-1:0]     inflight,
    output logic [15:0]          stall_count,
    output logic [15:0]          flush_count
);

    // Handshake: there is no valid/ready pair here. id_valid qualifies every ID-side input in
    // the same cycle; stall tells the PC/PR1 to hold and PR2 to take a bubble on the next edge.

    typedef enum logic [0:0] {RUN, HOLD} state_t;

    state_t state, state_next;

    logic [NUM_STAGES:1]  ent_valid;
    logic [NUM_STAGES:1]  ent_load;
    logic [ID_LENGTH-1:0] ent_dst [1:NUM_STAGES];
    logic [FWD_W-1:0]     ent_age [1:NUM_STAGES];
    logic [NUM_STAGES:1]  ent_ready;

    logic [ID_LENGTH-1:0] src [2];
    logic [1:0]           src_used;
    logic [1:0]           hit;
    logic [1:0]           hit_rdy;
    logic [FWD_W-1:0]     hit_pos [2];
    logic                 issue_en;
    logic [FWD_W-1:0]     valid_cnt;

    assign src[0]      = id_src1;
    assign src[1]      = id_src2;
    assign src_used[0] = id_src1_used;
    assign src_used[1] = id_src2_used;

    // An entry's age equals its position, so it is ready once it has reached its result latency.
    always_comb begin
        for (int k = 1; k <= NUM_STAGES; k++) begin
            ent_ready[k] = ent_age[k] >= (ent_load[k] ? FWD_W'(LOAD_LAT) : FWD_W'(ALU_LAT));
        end
    end

    // Youngest match per operand: scan from position 1 and stop at the first hit.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hit[s]     = 1'b0;
            hit_rdy[s] = 1'b0;
            hit_pos[s] = '0;
            for (int k = 1; k <= NUM_STAGES; k++) begin
                if (!hit[s] && id_valid && src_used[s] && ent_valid[k]
                    && (ent_dst[k] == src[s])) begin
                    hit[s]     = 1'b1;
                    hit_rdy[s] = ent_ready[k];
                    hit_pos[s] = FWD_W'(k);
                end
            end
        end
    end

    assign stall    = (hit[0] & ~hit_rdy[0]) | (hit[1] & ~hit_rdy[1]);
    assign fwd_sel1 = (hit[0] & hit_rdy[0] & ~stall) ? hit_pos[0] : '0;
    assign fwd_sel2 = (hit[1] & hit_rdy[1] & ~stall) ? hit_pos[1] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A held instruction never flushes IF or enters the scoreboard; a pending taken branch
    // therefore flushes in the first cycle its operands are available.
    always_comb begin
        state_next = state;
        flush_if   = 1'b0;
        issue_en   = 1'b0;
        case (state)
            RUN: begin
                if (stall) begin
                    state_next = HOLD;
                end else begin
                    flush_if = id_valid & id_branch_taken;
                    issue_en = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_next = RUN;
                    flush_if   = id_valid & id_branch_taken;
                    issue_en   = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            ent_load  <= '0;
            for (int k = 1; k <= NUM_STAGES; k++) begin
                ent_dst[k] <= '0;
                ent_age[k] <= '0;
            end
        end else begin
            ent_valid[1] <= issue_en & id_valid & id_wr_en;
            ent_load[1]  <= id_is_load;
            ent_dst[1]   <= id_dst;
            ent_age[1]   <= FWD_W'(1);
            for (int k = 2; k <= NUM_STAGES; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_dst[k]   <= ent_dst[k-1];
                ent_age[k]   <= ent_age[k-1] + FWD_W'(1);
            end
        end
    end

    always_comb begin
        valid_cnt = '0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            valid_cnt = valid_cnt + FWD_W'(ent_valid[k]);
        end
    end

    assign inflight = valid_cnt;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush_if && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = 16'h0000;
    assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard: default instance plus a LOAD_LAT=3 instance,
// expected outputs queued by the driver and checked by an independent monitor.
module tb_pipe_hazard_scoreboard;

    localparam int EW = 41;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_src1;
    logic [2:0]  id_src2;
    logic        id_src1_used;
    logic        id_src2_used;
    logic [2:0]  id_dst;
    logic        id_wr_en;
    logic        id_is_load;
    logic        id_branch_taken;

    logic        stall_a, flush_a, stall_b, flush_b;
    logic [1:0]  sel1_a, sel2_a, infl_a, sel1_b, sel2_b, infl_b;
    logic [15:0] sc_a, fc_a, sc_b, fc_b;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            tests;
    int            fails;
    int            sc_sum;
    int            fc_sum;

    pipe_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_dst(id_dst),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_branch_taken(id_branch_taken),
        .stall(stall_a), .flush_if(flush_a), .fwd_sel1(sel1_a), .fwd_sel2(sel2_a),
        .inflight(infl_a), .stall_count(sc_a), .flush_count(fc_a)
    );

    pipe_hazard_scoreboard #(.LOAD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_dst(id_dst),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_branch_taken(id_branch_taken),
        .stall(stall_b), .flush_if(flush_b), .fwd_sel1(sel1_b), .fwd_sel2(sel2_b),
        .inflight(infl_b), .stall_count(sc_b), .flush_count(fc_b)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
    end

    task automatic clear_inputs();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_src1_used = 0; id_src2_used = 0;
        id_dst = 0; id_wr_en = 0; id_is_load = 0; id_branch_taken = 0;
    endtask

    task automatic push_exp(input bit which, input bit st, input bit fl, input logic [1:0] s1,
                            input logic [1:0] s2, input logic [1:0] inf, input string nm);
        logic [15:0] sc_e, fc_e;
        sc_e = 16'h0;
        fc_e = 16'h0;
`ifdef HAZARD_PERF_COUNTERS_EN
        sc_e = 16'(sc_sum);
        fc_e = 16'(fc_sum);
`endif
        exp_q.push_back({which, st, fl, s1, s2, inf, sc_e, fc_e});
        name_q.push_back(nm);
        if (which == 1'b0) begin
            sc_sum += int'(st);
            fc_sum += int'(fl);
        end
    endtask

    // Driver tasks
    task automatic do_reset(input bit which);
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        sc_sum = 0;
        fc_sum = 0;
        push_exp(which, 0, 0, 2'd0, 2'd0, 2'd0, "reset_state");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input bit which, input bit v, input logic [2:0] s1, input bit u1,
                         input logic [2:0] s2, input bit u2, input logic [2:0] d, input bit wr,
                         input bit ld, input bit br, input bit e_st, input bit e_fl,
                         input logic [1:0] e_s1, input logic [1:0] e_s2, input logic [1:0] e_inf,
                         input string nm);
        @(negedge clk);
        id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
        id_dst = d; id_wr_en = wr; id_is_load = ld; id_branch_taken = br;
        push_exp(which, e_st, e_fl, e_s1, e_s2, e_inf, nm);
    endtask

    task automatic nop(input bit which, input logic [1:0] e_inf, input string nm);
        issue(which, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, e_inf, nm);
    endtask

    // Scoreboard monitor: samples 2 time units after each falling edge
    initial begin
        logic [EW-1:0] e, a;
        string         nm;
        tests = 0;
        fails = 0;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e[EW-1]) begin
                    a = {1'b1, stall_b, flush_b, sel1_b, sel2_b, infl_b, 16'h0, 16'h0};
                    e[31:0] = 32'h0;
                end else begin
                    a = {1'b0, stall_a, flush_a, sel1_a, sel2_a, infl_a, sc_a, fc_a};
                end
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL %s: got stall=%0b flush=%0b sel1=%0d sel2=%0d infl=%0d sc=%0d fc=%0d, expected stall=%0b flush=%0b sel1=%0d sel2=%0d infl=%0d sc=%0d fc=%0d",
                             nm, a[39], a[38], a[37:36], a[35:34], a[33:32], a[31:16], a[15:0],
                             e[39], e[38], e[37:36], e[35:34], e[33:32], e[31:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        sc_sum = 0;
        fc_sum = 0;
        do_reset(0);

        // ALU producer forwarded from EX, then from MEM
        nop(0, 2'd0, "idle");
        issue(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, "alu_r3");
        issue(0, 1, 3, 1, 0, 0, 6, 1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd1, "fwd_ex_src1");
        issue(0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, "fwd_mem_src2");
        issue(0, 0, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, "invalid_no_match");
        nop(0, 2'd1, "drain_a1");
        nop(0, 2'd0, "drain_a0");

        // Load-use: one stall, then forward from MEM; older ALU r1 forwarded from WB
        issue(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, "alu_r1");
        issue(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd1, "load_r5");
        issue(0, 1, 5, 1, 1, 1, 7, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2, "load_use_stall");
        issue(0, 1, 5, 1, 1, 1, 7, 1, 0, 0, 0, 0, 2'd2, 2'd3, 2'd2, "load_use_fwd");
        nop(0, 2'd2, "drain_b2");
        nop(0, 2'd1, "drain_b1");
        nop(0, 2'd1, "drain_b1b");
        nop(0, 2'd0, "drain_b0");

        // Youngest producer wins, including an unready youngest load over a ready older ALU op
        issue(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, "alu_r4_a");
        issue(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, "alu_r4_b");
        issue(0, 1, 4, 1, 4, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd2, "youngest_wins");
        issue(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, "alu_r4_c");
        issue(0, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd2, "load_r4_d");
        issue(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd2, "youngest_load_stall");
        issue(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, "youngest_load_fwd");
        nop(0, 2'd1, "drain_c1");
        nop(0, 2'd0, "drain_c0");

        // Taken branch with no hazard flushes immediately, for one cycle
        issue(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0, "branch_flush");
        nop(0, 2'd0, "branch_flush_done");

        // Stall and branch together: stall wins, flush follows; counters from a fresh reset
        do_reset(0);
        issue(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, "load_r5_br");
        issue(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd1, "stall_beats_branch");
        issue(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1, 2'd2, 2'd0, 2'd1, "flush_after_stall");
        nop(0, 2'd1, "counters_after");
        nop(0, 2'd0, "drain_d0");

        // Asynchronous reset in the middle of a stall
        issue(0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, "load_r2");
        issue(0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, "pre_rst_stall");
        @(negedge clk);
        sc_sum = 0;
        fc_sum = 0;
        push_exp(0, 0, 0, 2'd0, 2'd0, 2'd0, "async_rst_mid_stall");
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        issue(0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, "post_rst_no_fwd");

        // LOAD_LAT=3 instance: two stall cycles, then forward from WB
        do_reset(1);
        issue(1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, "lat3_load_r2");
        issue(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, "lat3_stall1");
        issue(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, "lat3_stall2");
        issue(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd1, "lat3_fwd");
        nop(1, 2'd0, "lat3_drain");

        // Final report
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #5;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
